// File: rtl/hacd_pkg.sv
// Shared types and defaults for the Hawk control/arbitration slice.
package hacd_pkg;

    localparam int HAWK_N_CH    = 4;
    localparam int HAWK_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        ARB      = 3'd1,
        LKP_REQ  = 3'd2,
        LKP_WAIT = 3'd3,
        TBL_UPD  = 3'd4
    } ctrl_arb_state_e;

endpackage

// File: rtl/hawk_rr_arb.sv
// Combinational round-robin picker: first eligible channel at or above ptr, wrapping.
module hawk_rr_arb
    import hacd_pkg::*;
#(
    parameter int N_CH = HAWK_N_CH,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] elig_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic            any_o,
    output logic [CH_W-1:0] grant_o
);

    logic [CH_W:0] idx;

    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = {1'b0, ptr_i} + (CH_W + 1)'(k);
            if (idx >= (CH_W + 1)'(N_CH)) begin
                idx = idx - (CH_W + 1)'(N_CH);
            end
            if (!any_o && elig_i[idx[CH_W-1:0]]) begin
                any_o   = 1'b1;
                grant_o = idx[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hawk_ctrl_arb.sv
// Multi-channel Hawk control unit: init sequencing, round-robin arbitration,
// single outstanding ATT lookup, miss/table-update wait and response timeout.
module hawk_ctrl_arb
    import hacd_pkg::*;
#(
    parameter int N_CH    = HAWK_N_CH,
    parameter int HPPA_W  = 48,
    parameter int PPA_W   = 48,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = HAWK_TIMEOUT,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     init_att_o,
    output logic                     init_list_o,
    input  logic                     init_att_done_i,
    input  logic                     init_list_done_i,
    input  logic [N_CH-1:0]          req_valid_i,
    input  logic [N_CH*HPPA_W-1:0]   req_hppa_i,
    output logic                     lkup_valid_o,
    output logic [HPPA_W-1:0]        lkup_hppa_o,
    output logic [CH_W-1:0]          lkup_ch_o,
    input  logic                     pgrd_mngr_ready_i,
    input  logic                     trnsl_allow_i,
    input  logic [PPA_W-1:0]         trnsl_ppa_i,
    input  logic                     tbl_update_i,
    input  logic [PPA_W-1:0]         tbl_way_i,
    input  logic                     tbl_update_done_i,
    output logic [N_CH-1:0]          ovrd_allow_o,
    output logic [N_CH*PPA_W-1:0]    ovrd_ppa_o,
    output logic                     busy_o,
    output logic                     timeout_err_o,
    output logic [CH_W-1:0]          timeout_ch_o
);

    ctrl_arb_state_e            state_q, state_d;
    logic                       initAtt_q, initAtt_d;
    logic                       initList_q, initList_d;
    logic [CH_W-1:0]            ptr_q, ptr_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [HPPA_W-1:0]          hppa_q, hppa_d;
    logic                       lkupValid_q, lkupValid_d;
    logic [TO_W-1:0]            timer_q, timer_d;
    logic [N_CH-1:0]            allow_q, allow_d;
    logic [N_CH-1:0][PPA_W-1:0] ppa_q, ppa_d;
    logic                       toErr_q, toErr_d;
    logic [CH_W-1:0]            toCh_q, toCh_d;

    logic [N_CH-1:0]            eligible;
    logic                       arbAny;
    logic [CH_W-1:0]            arbIdx;
    logic [CH_W-1:0]            nextPtr;
    logic [TO_W-1:0]            timerInc;
    logic                       timeoutHit;

    // A channel's valid may lag its grant by a cycle, so mask it during the pulse.
    assign eligible = req_valid_i & ~allow_q;

    hawk_rr_arb #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_arb (
        .elig_i  (eligible),
        .ptr_i   (ptr_q),
        .any_o   (arbAny),
        .grant_o (arbIdx)
    );

    assign nextPtr    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
    assign timerInc   = (&timer_q) ? timer_q : timer_q + 1'b1;
    assign timeoutHit = (TIMEOUT != 0) && (timer_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        initAtt_d   = initAtt_q;
        initList_d  = initList_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        hppa_d      = hppa_q;
        lkupValid_d = lkupValid_q;
        timer_d     = timer_q;
        allow_d     = '0;
        ppa_d       = ppa_q;
        toErr_d     = 1'b0;
        toCh_d      = toCh_q;

        case (state_q)
            INIT: begin
                if (init_att_done_i) initAtt_d = 1'b0;
                if (init_list_done_i) initList_d = 1'b0;
                if (!initAtt_q && !initList_q) state_d = ARB;
            end
            ARB: begin
                if (arbAny) begin
                    ch_d        = arbIdx;
                    hppa_d      = req_hppa_i[int'(arbIdx)*HPPA_W +: HPPA_W];
                    lkupValid_d = 1'b1;
                    state_d     = LKP_REQ;
                end
            end
            LKP_REQ: begin
                if (pgrd_mngr_ready_i) begin
                    lkupValid_d = 1'b0;
                    timer_d     = '0;
                    state_d     = LKP_WAIT;
                end
            end
            LKP_WAIT: begin
                timer_d = timerInc;
                // A hit takes priority over a simultaneous miss, and both beat the timeout.
                if (trnsl_allow_i) begin
                    ppa_d[ch_q]   = trnsl_ppa_i;
                    allow_d[ch_q] = 1'b1;
                    ptr_d         = nextPtr;
                    state_d       = ARB;
                end else if (tbl_update_i) begin
                    ppa_d[ch_q] = tbl_way_i;
                    timer_d     = '0;
                    state_d     = TBL_UPD;
                end else if (timeoutHit) begin
                    toErr_d = 1'b1;
                    toCh_d  = ch_q;
                    ptr_d   = nextPtr;
                    state_d = ARB;
                end
            end
            TBL_UPD: begin
                timer_d = timerInc;
                if (tbl_update_done_i) begin
                    allow_d[ch_q] = 1'b1;
                    ptr_d         = nextPtr;
                    state_d       = ARB;
                end else if (timeoutHit) begin
                    toErr_d = 1'b1;
                    toCh_d  = ch_q;
                    ptr_d   = nextPtr;
                    state_d = ARB;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            initAtt_q   <= 1'b1;
            initList_q  <= 1'b1;
            ptr_q       <= '0;
            ch_q        <= '0;
            hppa_q      <= '0;
            lkupValid_q <= 1'b0;
            timer_q     <= '0;
            allow_q     <= '0;
            ppa_q       <= '0;
            toErr_q     <= 1'b0;
            toCh_q      <= '0;
        end else begin
            state_q     <= state_d;
            initAtt_q   <= initAtt_d;
            initList_q  <= initList_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            hppa_q      <= hppa_d;
            lkupValid_q <= lkupValid_d;
            timer_q     <= timer_d;
            allow_q     <= allow_d;
            ppa_q       <= ppa_d;
            toErr_q     <= toErr_d;
            toCh_q      <= toCh_d;
        end
    end

    assign init_att_o    = initAtt_q;
    assign init_list_o   = initList_q;
    assign lkup_valid_o  = lkupValid_q;
    assign lkup_hppa_o   = hppa_q;
    assign lkup_ch_o     = ch_q;
    assign ovrd_allow_o  = allow_q;
    assign ovrd_ppa_o    = ppa_q;
    assign busy_o        = (state_q != ARB);
    assign timeout_err_o = toErr_q;
    assign timeout_ch_o  = toCh_q;

endmodule

// File: tb/tb_hawk_ctrl_arb.sv
// Scenario bench for hawk_ctrl_arb: grants are scoreboarded as responses are driven.
// A second instance with a short timeout exercises the timeout path in isolation.
module tb_hawk_ctrl_arb;

    localparam int N_CH   = 4;
    localparam int HPPA_W = 48;
    localparam int PPA_W  = 48;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [PPA_W-1:0] ppa;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, initAttDone, initListDone, ready;
    logic [N_CH-1:0]        reqValid, toReqValid;
    logic [N_CH*HPPA_W-1:0] reqHppa;
    logic                   trnslAllow, tblUpdate, tblDone;
    logic [PPA_W-1:0]       trnslPpa, tblWay;

    logic                   initAtt, initList, lkupValid, busy, toErr;
    logic [HPPA_W-1:0]      lkupHppa;
    logic [CH_W-1:0]        lkupCh, toCh;
    logic [N_CH-1:0]        ovrdAllow;
    logic [N_CH*PPA_W-1:0]  ovrdPpa;

    logic                   tInitAtt, tInitList, tLkupValid, tBusy, tErr;
    logic [HPPA_W-1:0]      tLkupHppa;
    logic [CH_W-1:0]        tLkupCh, tCh;
    logic [N_CH-1:0]        tAllow;
    logic [N_CH*PPA_W-1:0]  tPpa;

    int   nChecks = 0;
    int   nErrors = 0;
    int   allowPulses = 0;
    int   toAllowPulses = 0;
    exp_t sbQ[$];
    logic [PPA_W-1:0] expPpa [N_CH];

    hawk_ctrl_arb #(.N_CH(N_CH), .HPPA_W(HPPA_W), .PPA_W(PPA_W), .TO_W(16), .TIMEOUT(1024)) dut (
        .clk_i(clk), .rst_i(rst),
        .init_att_o(initAtt), .init_list_o(initList),
        .init_att_done_i(initAttDone), .init_list_done_i(initListDone),
        .req_valid_i(reqValid), .req_hppa_i(reqHppa),
        .lkup_valid_o(lkupValid), .lkup_hppa_o(lkupHppa), .lkup_ch_o(lkupCh),
        .pgrd_mngr_ready_i(ready),
        .trnsl_allow_i(trnslAllow), .trnsl_ppa_i(trnslPpa),
        .tbl_update_i(tblUpdate), .tbl_way_i(tblWay), .tbl_update_done_i(tblDone),
        .ovrd_allow_o(ovrdAllow), .ovrd_ppa_o(ovrdPpa), .busy_o(busy),
        .timeout_err_o(toErr), .timeout_ch_o(toCh)
    );

    hawk_ctrl_arb #(.N_CH(N_CH), .HPPA_W(HPPA_W), .PPA_W(PPA_W), .TO_W(16), .TIMEOUT(8)) dutTo (
        .clk_i(clk), .rst_i(rst),
        .init_att_o(tInitAtt), .init_list_o(tInitList),
        .init_att_done_i(initAttDone), .init_list_done_i(initListDone),
        .req_valid_i(toReqValid), .req_hppa_i(reqHppa),
        .lkup_valid_o(tLkupValid), .lkup_hppa_o(tLkupHppa), .lkup_ch_o(tLkupCh),
        .pgrd_mngr_ready_i(ready),
        .trnsl_allow_i(1'b0), .trnsl_ppa_i('0),
        .tbl_update_i(1'b0), .tbl_way_i('0), .tbl_update_done_i(1'b0),
        .ovrd_allow_o(tAllow), .ovrd_ppa_o(tPpa), .busy_o(tBusy),
        .timeout_err_o(tErr), .timeout_ch_o(tCh)
    );

    always @(negedge clk) begin
        if (|ovrdAllow) allowPulses++;
        if (|tAllow) toAllowPulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setHppa(input int ch, input logic [HPPA_W-1:0] v);
        reqHppa[ch*HPPA_W +: HPPA_W] = v;
    endtask

    function automatic logic [PPA_W-1:0] ppaOf(input logic [N_CH*PPA_W-1:0] v, input int ch);
        return v[ch*PPA_W +: PPA_W];
    endfunction

    task automatic test_reset;
        logic expAtt, expList, expBusy;
        rst = 1'b1;
        tick; tick;
        nChecks++; if (initAtt !== 1'b1) begin nErrors++; $display("[TB] FAIL reset_init_att: got %b want 1", initAtt); end
        nChecks++; if (initList !== 1'b1) begin nErrors++; $display("[TB] FAIL reset_init_list: got %b want 1", initList); end
        nChecks++; if (lkupValid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_lkup_valid: got %b want 0", lkupValid); end
        nChecks++; if (ovrdAllow !== '0) begin nErrors++; $display("[TB] FAIL reset_allow: got %b want 0", ovrdAllow); end
        nChecks++; if (ovrdPpa !== '0) begin nErrors++; $display("[TB] FAIL reset_ppa: got %h want 0", ovrdPpa); end
        nChecks++; if (toErr !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_timeout_err: got %b want 0", toErr); end
        nChecks++; if (busy !== 1'b1) begin nErrors++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
        rst = 1'b0;
        setHppa(0, 48'h9999);
        for (int c = 0; c < 10; c++) begin
            expAtt  = (c < 7);
            expList = (c < 4);
            expBusy = (c < 8);
            nChecks++; if (initAtt !== expAtt) begin nErrors++; $display("[TB] FAIL init_att c%0d: got %b want %b", c, initAtt, expAtt); end
            nChecks++; if (initList !== expList) begin nErrors++; $display("[TB] FAIL init_list c%0d: got %b want %b", c, initList, expList); end
            nChecks++; if (busy !== expBusy) begin nErrors++; $display("[TB] FAIL init_busy c%0d: got %b want %b", c, busy, expBusy); end
            nChecks++; if (lkupValid !== 1'b0) begin nErrors++; $display("[TB] FAIL init_no_lkup c%0d: got %b want 0", c, lkupValid); end
            reqValid     = (c < 8) ? 4'b0001 : 4'b0000;
            initListDone = (c == 3);
            initAttDone  = (c == 6);
            tick;
        end
        initListDone = 1'b0;
        initAttDone  = 1'b0;
    endtask

    task automatic test_single_hit;
        exp_t e;
        reqValid = 4'b0100;
        setHppa(2, 48'h1000);
        tick;
        nChecks++; if (lkupValid !== 1'b1) begin nErrors++; $display("[TB] FAIL hit_lkup_valid: got %b want 1", lkupValid); end
        nChecks++; if (lkupCh !== 2'd2) begin nErrors++; $display("[TB] FAIL hit_lkup_ch: got %0d want 2", lkupCh); end
        nChecks++; if (lkupHppa !== 48'h1000) begin nErrors++; $display("[TB] FAIL hit_lkup_hppa: got %h want 1000", lkupHppa); end
        tick;
        nChecks++; if (lkupValid !== 1'b0) begin nErrors++; $display("[TB] FAIL hit_lkup_drop: got %b want 0", lkupValid); end
        nChecks++; if (ovrdAllow !== 4'b0000) begin nErrors++; $display("[TB] FAIL hit_early_allow: got %b want 0000", ovrdAllow); end
        trnslAllow = 1'b1;
        trnslPpa   = 48'hABC;
        e.ch = 2'd2; e.ppa = 48'hABC;
        sbQ.push_back(e);
        expPpa[2] = 48'hABC;
        tick;
        trnslAllow = 1'b0;
        if (sbQ.size() == 0) begin
            nChecks++; nErrors++; $display("[TB] FAIL hit_sb_empty: got empty want entry");
        end else begin
            e = sbQ.pop_front();
            nChecks++; if (ovrdAllow !== (4'b0001 << e.ch)) begin nErrors++; $display("[TB] FAIL hit_allow: got %b want %b", ovrdAllow, 4'b0001 << e.ch); end
            nChecks++; if (ppaOf(ovrdPpa, int'(e.ch)) !== e.ppa) begin nErrors++; $display("[TB] FAIL hit_ppa: got %h want %h", ppaOf(ovrdPpa, int'(e.ch)), e.ppa); end
        end
        tick;
        reqValid = 4'b0000;
        nChecks++; if (ovrdAllow !== 4'b0000) begin nErrors++; $display("[TB] FAIL hit_one_cycle: got %b want 0000", ovrdAllow); end
        nChecks++; if (lkupValid !== 1'b0) begin nErrors++; $display("[TB] FAIL hit_grant_mask: got %b want 0", lkupValid); end
        nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL hit_idle: got %b want 0", busy); end
        nChecks++; if (ppaOf(ovrdPpa, 2) !== expPpa[2]) begin nErrors++; $display("[TB] FAIL hit_ppa_persist: got %h want %h", ppaOf(ovrdPpa, 2), expPpa[2]); end
    endtask

    task automatic test_round_robin;
        exp_t e;
        int   expCh;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        for (int k = 0; k < N_CH; k++) expPpa[k] = '0;
        initAttDone  = 1'b1;
        initListDone = 1'b1;
        tick;
        initAttDone  = 1'b0;
        initListDone = 1'b0;
        tick;
        nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL rr_init_same_cycle: got busy %b want 0", busy); end
        reqValid = 4'b1111;
        for (int k = 0; k < N_CH; k++) setHppa(k, 48'h2000 + 48'(k));
        for (int n = 0; n < 5; n++) begin
            expCh = n % N_CH;
            tick;
            nChecks++; if (lkupCh !== 2'(expCh)) begin nErrors++; $display("[TB] FAIL rr_order n%0d: got ch %0d want %0d", n, lkupCh, expCh); end
            nChecks++; if (lkupHppa !== 48'h2000 + 48'(expCh)) begin nErrors++; $display("[TB] FAIL rr_hppa n%0d: got %h want %h", n, lkupHppa, 48'h2000 + 48'(expCh)); end
            tick;
            trnslAllow = 1'b1;
            trnslPpa   = 48'h300 + 48'(n);
            e.ch = 2'(expCh); e.ppa = trnslPpa;
            sbQ.push_back(e);
            expPpa[expCh] = trnslPpa;
            tick;
            trnslAllow = 1'b0;
            if (n == 4) reqValid = 4'b0000;
            if (sbQ.size() == 0) begin
                nChecks++; nErrors++; $display("[TB] FAIL rr_sb_empty n%0d: got empty want entry", n);
            end else begin
                e = sbQ.pop_front();
                nChecks++; if (ovrdAllow !== (4'b0001 << e.ch)) begin nErrors++; $display("[TB] FAIL rr_allow n%0d: got %b want %b", n, ovrdAllow, 4'b0001 << e.ch); end
                nChecks++; if (ppaOf(ovrdPpa, int'(e.ch)) !== e.ppa) begin nErrors++; $display("[TB] FAIL rr_ppa n%0d: got %h want %h", n, ppaOf(ovrdPpa, int'(e.ch)), e.ppa); end
            end
        end
        tick;
        nChecks++; if (lkupValid !== 1'b0) begin nErrors++; $display("[TB] FAIL rr_quiet: got %b want 0", lkupValid); end
        for (int k = 0; k < N_CH; k++) begin
            nChecks++; if (ppaOf(ovrdPpa, k) !== expPpa[k]) begin nErrors++; $display("[TB] FAIL rr_ppa_hold ch%0d: got %h want %h", k, ppaOf(ovrdPpa, k), expPpa[k]); end
        end
    endtask

    task automatic test_miss;
        exp_t e;
        reqValid = 4'b1000;
        setHppa(3, 48'h4000);
        tick;
        nChecks++; if (lkupCh !== 2'd3) begin nErrors++; $display("[TB] FAIL miss_lkup_ch: got %0d want 3", lkupCh); end
        tick;
        tblUpdate = 1'b1;
        tblWay    = 48'h55;
        expPpa[3] = 48'h55;
        tick;
        tblUpdate = 1'b0;
        nChecks++; if (ppaOf(ovrdPpa, 3) !== expPpa[3]) begin nErrors++; $display("[TB] FAIL miss_way_ppa: got %h want %h", ppaOf(ovrdPpa, 3), expPpa[3]); end
        nChecks++; if (ppaOf(ovrdPpa, 2) !== expPpa[2]) begin nErrors++; $display("[TB] FAIL miss_other_ppa: got %h want %h", ppaOf(ovrdPpa, 2), expPpa[2]); end
        for (int i = 0; i < 10; i++) begin
            nChecks++; if (ovrdAllow !== 4'b0000) begin nErrors++; $display("[TB] FAIL miss_early_allow i%0d: got %b want 0000", i, ovrdAllow); end
            nChecks++; if (busy !== 1'b1) begin nErrors++; $display("[TB] FAIL miss_busy i%0d: got %b want 1", i, busy); end
            if (i < 9) tick;
        end
        tblDone = 1'b1;
        e.ch = 2'd3; e.ppa = 48'h55;
        sbQ.push_back(e);
        tick;
        tblDone  = 1'b0;
        reqValid = 4'b0000;
        if (sbQ.size() == 0) begin
            nChecks++; nErrors++; $display("[TB] FAIL miss_sb_empty: got empty want entry");
        end else begin
            e = sbQ.pop_front();
            nChecks++; if (ovrdAllow !== (4'b0001 << e.ch)) begin nErrors++; $display("[TB] FAIL miss_allow: got %b want %b", ovrdAllow, 4'b0001 << e.ch); end
            nChecks++; if (ppaOf(ovrdPpa, int'(e.ch)) !== e.ppa) begin nErrors++; $display("[TB] FAIL miss_ppa: got %h want %h", ppaOf(ovrdPpa, int'(e.ch)), e.ppa); end
        end
        tick;
        nChecks++; if (ovrdAllow !== 4'b0000) begin nErrors++; $display("[TB] FAIL miss_one_cycle: got %b want 0000", ovrdAllow); end
        nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL miss_idle: got %b want 0", busy); end
    endtask

    task automatic test_timeout;
        toReqValid = 4'b0010;
        setHppa(1, 48'h5000);
        tick;
        nChecks++; if (tLkupCh !== 2'd1) begin nErrors++; $display("[TB] FAIL to_lkup_ch: got %0d want 1", tLkupCh); end
        tick;
        for (int k = 1; k <= 8; k++) begin
            nChecks++; if (tErr !== 1'b0) begin nErrors++; $display("[TB] FAIL to_early k%0d: got %b want 0", k, tErr); end
            nChecks++; if (tBusy !== 1'b1) begin nErrors++; $display("[TB] FAIL to_busy k%0d: got %b want 1", k, tBusy); end
            tick;
        end
        nChecks++; if (tErr !== 1'b1) begin nErrors++; $display("[TB] FAIL to_pulse: got %b want 1", tErr); end
        nChecks++; if (tCh !== 2'd1) begin nErrors++; $display("[TB] FAIL to_ch: got %0d want 1", tCh); end
        nChecks++; if (tAllow !== 4'b0000) begin nErrors++; $display("[TB] FAIL to_no_allow: got %b want 0000", tAllow); end
        nChecks++; if (tBusy !== 1'b0) begin nErrors++; $display("[TB] FAIL to_back_to_arb: got %b want 0", tBusy); end
        toReqValid = 4'b1010;
        tick;
        toReqValid = 4'b0000;
        nChecks++; if (tErr !== 1'b0) begin nErrors++; $display("[TB] FAIL to_one_cycle: got %b want 0", tErr); end
        nChecks++; if (tLkupCh !== 2'd3) begin nErrors++; $display("[TB] FAIL to_next_ch: got %0d want 3", tLkupCh); end
        nChecks++; if (toAllowPulses !== 0) begin nErrors++; $display("[TB] FAIL to_allow_count: got %0d want 0", toAllowPulses); end
    endtask

    task automatic test_hit_beats_update;
        exp_t e;
        reqValid = 4'b0001;
        setHppa(0, 48'h6000);
        tick;
        nChecks++; if (lkupCh !== 2'd0) begin nErrors++; $display("[TB] FAIL both_lkup_ch: got %0d want 0", lkupCh); end
        tick;
        trnslAllow = 1'b1;
        trnslPpa   = 48'h777;
        tblUpdate  = 1'b1;
        tblWay     = 48'h99;
        e.ch = 2'd0; e.ppa = 48'h777;
        sbQ.push_back(e);
        expPpa[0] = 48'h777;
        tick;
        trnslAllow = 1'b0;
        tblUpdate  = 1'b0;
        reqValid   = 4'b0000;
        if (sbQ.size() == 0) begin
            nChecks++; nErrors++; $display("[TB] FAIL both_sb_empty: got empty want entry");
        end else begin
            e = sbQ.pop_front();
            nChecks++; if (ovrdAllow !== (4'b0001 << e.ch)) begin nErrors++; $display("[TB] FAIL both_allow: got %b want %b", ovrdAllow, 4'b0001 << e.ch); end
            nChecks++; if (ppaOf(ovrdPpa, int'(e.ch)) !== e.ppa) begin nErrors++; $display("[TB] FAIL both_ppa: got %h want %h", ppaOf(ovrdPpa, int'(e.ch)), e.ppa); end
        end
        nChecks++; if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL both_not_tbl_upd: got busy %b want 0", busy); end
        tick;
        nChecks++; if (ppaOf(ovrdPpa, 0) !== expPpa[0]) begin nErrors++; $display("[TB] FAIL both_ppa_hold: got %h want %h", ppaOf(ovrdPpa, 0), expPpa[0]); end
        nChecks++; if (allowPulses !== 8) begin nErrors++; $display("[TB] FAIL allow_count: got %0d want 8", allowPulses); end
    endtask

    task automatic test_reset_mid_wait;
        reqValid = 4'b0010;
        setHppa(1, 48'h8000);
        tick;
        nChecks++; if (lkupCh !== 2'd1) begin nErrors++; $display("[TB] FAIL rst_lkup_ch: got %0d want 1", lkupCh); end
        tick;
        rst        = 1'b1;
        trnslAllow = 1'b1;
        trnslPpa   = 48'hDEAD;
        tick;
        rst        = 1'b0;
        trnslAllow = 1'b0;
        reqValid   = 4'b0000;
        nChecks++; if (initAtt !== 1'b1) begin nErrors++; $display("[TB] FAIL rst_init_att: got %b want 1", initAtt); end
        nChecks++; if (initList !== 1'b1) begin nErrors++; $display("[TB] FAIL rst_init_list: got %b want 1", initList); end
        nChecks++; if (ovrdAllow !== 4'b0000) begin nErrors++; $display("[TB] FAIL rst_no_grant: got %b want 0000", ovrdAllow); end
        nChecks++; if (ovrdPpa !== '0) begin nErrors++; $display("[TB] FAIL rst_ppa: got %h want 0", ovrdPpa); end
        nChecks++; if (lkupValid !== 1'b0) begin nErrors++; $display("[TB] FAIL rst_lkup_valid: got %b want 0", lkupValid); end
        nChecks++; if (lkupCh !== 2'd0) begin nErrors++; $display("[TB] FAIL rst_lkup_ch0: got %0d want 0", lkupCh); end
        nChecks++; if (lkupHppa !== '0) begin nErrors++; $display("[TB] FAIL rst_lkup_hppa: got %h want 0", lkupHppa); end
        nChecks++; if (busy !== 1'b1) begin nErrors++; $display("[TB] FAIL rst_busy: got %b want 1", busy); end
        tick;
        nChecks++; if (ovrdAllow !== 4'b0000) begin nErrors++; $display("[TB] FAIL rst_no_late_grant: got %b want 0000", ovrdAllow); end
        nChecks++; if (initAtt !== 1'b1) begin nErrors++; $display("[TB] FAIL rst_stay_init: got %b want 1", initAtt); end
    endtask

    initial begin
        rst          = 1'b1;
        initAttDone  = 1'b0;
        initListDone = 1'b0;
        ready        = 1'b1;
        reqValid     = '0;
        toReqValid   = '0;
        reqHppa      = '0;
        trnslAllow   = 1'b0;
        trnslPpa     = '0;
        tblUpdate    = 1'b0;
        tblWay       = '0;
        tblDone      = 1'b0;
        for (int k = 0; k < N_CH; k++) expPpa[k] = '0;

        test_reset;
        test_single_hit;
        test_round_robin;
        test_miss;
        test_timeout;
        test_hit_beats_update;
        test_reset_mid_wait;

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
